// File: rtl/spram_pkg.sv
// spram_pkg: read-mode constants and byte parity helper for spram_be_pipe
package spram_pkg;
  localparam int RD_FIRST = 0;
  localparam int WR_FIRST = 1;
  // Even-parity bit for one byte: stored bit makes the 9-bit group even
  function automatic logic par8(input logic [7:0] b);
    return ^b;
  endfunction
endpackage

// File: rtl/spram_rsp_fifo.sv
// spram_rsp_fifo: small valid/ready response buffer, arbitrary depth, output zeroed when empty
module spram_rsp_fifo #(
  parameter int W = 8,
  parameter int D = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  localparam int PW = D > 1 ? $clog2(D) : 1;
  localparam int CW = $clog2(D + 1);
  logic [W-1:0] mem_q [D];
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic push, pop;
  // Occupancy, wrap-around pointers and masked head data
  always_comb begin
    in_ready = cnt_q != CW'(D);
    out_valid = cnt_q != '0;
    push = in_valid & in_ready;
    pop = out_valid & out_ready;
    wp_d = push ? (wp_q == PW'(D - 1) ? '0 : wp_q + 1'b1) : wp_q;
    rp_d = pop ? (rp_q == PW'(D - 1) ? '0 : rp_q + 1'b1) : rp_q;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
    out_data = out_valid ? mem_q[rp_q] : '0;
  end
  // Pointer and count state, discarded on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
    end
  end
  // Entry storage; the head entry is never overwritten while occupied
  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= in_data;
  end
endmodule

// File: rtl/spram_be_pipe.sv
// spram_be_pipe: byte-enabled single-port RAM with valid/ready response pipe; SPRAM_PARITY_EN adds per-byte parity
module spram_be_pipe
  import spram_pkg::*;
#(
  parameter int AW = 12,
  parameter int DW = 32,
  parameter int RD_MODE = RD_FIRST,
  parameter int OUT_REG = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [AW-1:0]   req_addr,
  input  logic [DW-1:0]   req_wdata,
  input  logic [DW/8-1:0] req_be,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [DW-1:0]   rsp_rdata,
  output logic [DW/8-1:0] rsp_perr
);
  localparam int NB = DW / 8;
  localparam int LAT = 1 + OUT_REG;
  localparam int CAP = LAT + 1;
  localparam int CW = $clog2(CAP + 1);
  localparam int RW = DW + NB;
  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] old_w, new_w;
  logic [NB-1:0] old_err, new_err;
  logic [RW-1:0] rd_s, pd_q, pd_d, f_in;
  logic [CW-1:0] infl_q, infl_d;
  logic pv_q, pv_d, f_in_valid, f_in_ready, acc, pop, live_q;
`ifdef SPRAM_PARITY_EN
  logic [NB-1:0] par [2**AW];
  logic [NB-1:0] old_par, new_par;
  // Parity bits for the merged word: written lanes get fresh parity
  always_comb begin
    old_par = par[req_addr];
    new_par = old_par;
    for (int i = 0; i < NB; i++) new_par[i] = req_be[i] ? par8(req_wdata[8*i+:8]) : old_par[i];
  end
`endif
  // Read the addressed word, merge enabled lanes, pick old or merged view
  always_comb begin
    old_w = mem[req_addr];
    new_w = old_w;
    old_err = '0;
    new_err = '0;
    for (int i = 0; i < NB; i++) begin
      new_w[8*i+:8] = req_be[i] ? req_wdata[8*i+:8] : old_w[8*i+:8];
`ifdef SPRAM_PARITY_EN
      old_err[i] = par8(old_w[8*i+:8]) ^ old_par[i];
`endif
      new_err[i] = req_be[i] ? 1'b0 : old_err[i];
    end
    rd_s = RD_MODE == WR_FIRST ? {new_err, new_w} : {old_err, old_w};
  end
  assign req_ready = live_q & (infl_q < CW'(CAP)) & f_in_ready;
  // Handshakes, in-flight count and optional output stage feed
  always_comb begin
    acc = req_valid & req_ready;
    pop = rsp_valid & rsp_ready;
    infl_d = infl_q + CW'(acc) - CW'(pop);
    pv_d = acc;
    pd_d = acc ? rd_s : pd_q;
    f_in_valid = OUT_REG != 0 ? pv_q : acc;
    f_in = OUT_REG != 0 ? pd_q : rd_s;
  end
  // Control state; live_q holds req_ready low until the first edge after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      live_q <= 1'b0;
      infl_q <= '0;
      pv_q <= 1'b0;
      pd_q <= '0;
    end else begin
      live_q <= 1'b1;
      infl_q <= infl_d;
      pv_q <= pv_d;
      pd_q <= pd_d;
    end
  end
  // Memory write of the merged word; contents survive reset
  always_ff @(posedge clk) begin
    if (acc) begin
      mem[req_addr] <= new_w;
`ifdef SPRAM_PARITY_EN
      par[req_addr] <= new_par;
`endif
    end
  end
  spram_rsp_fifo #(.W(RW), .D(CAP)) u_fifo (
    .clk(clk),
    .rst(rst),
    .in_valid(f_in_valid),
    .in_ready(f_in_ready),
    .in_data(f_in),
    .out_valid(rsp_valid),
    .out_ready(rsp_ready),
    .out_data({rsp_perr, rsp_rdata})
  );
endmodule

// File: tb/tb_spram_be_pipe.sv
// tb_spram_be_pipe: random and directed checks of two spram_be_pipe configurations against a word-level model
module tb_spram_be_pipe;
  logic clk = 1'b0;
  logic rst;
  logic req_valid[2], req_ready[2], rsp_valid[2], rsp_ready[2];
  logic [11:0] req_addr[2];
  logic [31:0] req_wdata[2], rsp_rdata[2];
  logic [3:0] req_be[2], rsp_perr[2];
  int n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  spram_be_pipe #(.AW(12), .DW(32), .RD_MODE(0), .OUT_REG(0)) u0 (
    .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]), .rsp_perr(rsp_perr[0]));
  spram_be_pipe #(.AW(12), .DW(32), .RD_MODE(1), .OUT_REG(1)) u1 (
    .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]), .rsp_perr(rsp_perr[1]));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] bm(input logic [3:0] m);
    for (int i = 0; i < 4; i++) bm[8*i+:8] = {8{m[i]}};
  endfunction

  // Model: per-instance memory, parity-error flags, known-lane masks, expected-response ring
  logic [31:0] mm[2][4096];
  logic [3:0] pm[2][4096], km[2][4096];
  logic [31:0] eq_d[2][64];
  logic [3:0] eq_p[2][64], eq_m[2][64];
  int wp[2], rp[2];
  logic hold_v[2];
  logic [35:0] hold[2];
  logic [11:0] ma;
  logic [31:0] mo, mn;
  logic [3:0] mpo, mpn, mko, mkn;

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        wp[k] = 0;
        rp[k] = 0;
        hold_v[k] = 1'b0;
      end else begin
        if (hold_v[k]) chk("hold", {rsp_valid[k], rsp_perr[k], rsp_rdata[k]}, {1'b1, hold[k]});
        if (req_valid[k] && req_ready[k]) begin
          ma = req_addr[k];
          mo = mm[k][ma];
          mpo = pm[k][ma];
          mko = km[k][ma];
          for (int i = 0; i < 4; i++) begin
            mn[8*i+:8] = req_be[k][i] ? req_wdata[k][8*i+:8] : mo[8*i+:8];
            mpn[i] = req_be[k][i] ? 1'b0 : mpo[i];
            mkn[i] = req_be[k][i] | mko[i];
          end
          mm[k][ma] = mn;
          pm[k][ma] = mpn;
          km[k][ma] = mkn;
          eq_d[k][wp[k] % 64] = k == 1 ? mn : mo;
          eq_p[k][wp[k] % 64] = k == 1 ? mpn : mpo;
          eq_m[k][wp[k] % 64] = k == 1 ? mkn : mko;
          wp[k]++;
        end
        if (rsp_valid[k] && rsp_ready[k]) begin
          chk("rsp_outstanding", 64'(wp[k] > rp[k]), 1);
          if (wp[k] > rp[k]) begin
            chk("rdata", rsp_rdata[k] & bm(eq_m[k][rp[k] % 64]), eq_d[k][rp[k] % 64] & bm(eq_m[k][rp[k] % 64]));
            chk("perr", rsp_perr[k] & eq_m[k][rp[k] % 64], eq_p[k][rp[k] % 64] & eq_m[k][rp[k] % 64]);
            rp[k]++;
          end
        end
        hold_v[k] = rsp_valid[k] && !rsp_ready[k];
        hold[k] = {rsp_perr[k], rsp_rdata[k]};
      end
    end
  end

  task automatic send(input int k, input logic [11:0] a, input logic [31:0] d, input logic [3:0] be);
    int n = 0;
    req_addr[k] = a;
    req_wdata[k] = d;
    req_be[k] = be;
    req_valid[k] = 1'b1;
    @(negedge clk);
    while (!req_ready[k] && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n >= 50) chk("send_timeout", req_ready[k], 1);
    @(posedge clk);
    #1 req_valid[k] = 1'b0;
  endtask

  task automatic xfer(input int k, input logic [11:0] a, input logic [31:0] d, input logic [3:0] be,
                      input logic [31:0] exp, input logic [3:0] ep, input string tag);
    int n = 1;
    send(k, a, d, be);
    @(negedge clk);
    while (!rsp_valid[k] && n < 10) begin
      n++;
      @(negedge clk);
    end
    chk({tag, "_lat"}, n, k + 1);
    chk(tag, rsp_rdata[k], exp);
    chk({tag, "_perr"}, rsp_perr[k], ep);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rnd(input int k);
    int acc = 0, cyc = 0;
    while (acc < 5000 && cyc < 40000) begin
      req_valid[k] = ($urandom % 4) != 0;
      req_addr[k] = 12'($urandom % 32);
      req_wdata[k] = $urandom;
      req_be[k] = 4'($urandom);
      rsp_ready[k] = ($urandom % 4) != 0;
      @(negedge clk);
      if (req_valid[k] && req_ready[k]) acc++;
      @(posedge clk);
      #1 cyc++;
    end
    req_valid[k] = 1'b0;
    rsp_ready[k] = 1'b1;
    chk("rnd_accepts", acc, 5000);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc, cnt;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 1'b0;
      req_addr[k] = '0;
      req_wdata[k] = '0;
      req_be[k] = '0;
      rsp_ready[k] = 1'b1;
      for (int a = 0; a < 4096; a++) begin
        km[k][a] = '0;
        pm[k][a] = '0;
        mm[k][a] = '0;
      end
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_ready", req_ready[k], 0);
      chk("rst_valid", rsp_valid[k], 0);
      chk("rst_rdata", rsp_rdata[k], 0);
      chk("rst_perr", rsp_perr[k], 0);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("ready_before_edge", req_ready[0], 0);
    @(negedge clk);
    chk("ready_after_edge0", req_ready[0], 1);
    chk("ready_after_edge1", req_ready[1], 1);
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++)
      for (int a = 0; a < 32; a++) send(k, 12'(a), $urandom, 4'hF);
    idle(6);
    // Write then immediate read of the same word
    send(0, 12'h010, 32'hDEADBEEF, 4'hF);
    send(0, 12'h010, 32'h0, 4'h0);
    @(negedge clk);
    chk("b2b_valid", rsp_valid[0], 1);
    chk("b2b_rdata", rsp_rdata[0], 32'hDEADBEEF);
    @(posedge clk);
    #1;
    // Partial byte-enable write in both read modes
    for (int k = 0; k < 2; k++) begin
      send(k, 12'h020, 32'h11223344, 4'hF);
      idle(6);
      xfer(k, 12'h020, 32'hAABBCCDD, 4'h5, k == 1 ? 32'h11BB33DD : 32'h11223344, 4'h0, "be_write");
      xfer(k, 12'h020, 32'h0, 4'h0, 32'h11BB33DD, 4'h0, "be_read");
    end
    // Back-pressure on the registered-output instance
    rsp_ready[1] = 1'b0;
    acc = 0;
    req_valid[1] = 1'b1;
    req_be[1] = 4'h0;
    for (int i = 0; i < 10; i++) begin
      req_addr[1] = 12'(i);
      @(negedge clk);
      if (req_ready[1]) acc++;
      @(posedge clk);
      #1;
    end
    req_valid[1] = 1'b0;
    chk("stall_accepts", acc, 3);
    @(negedge clk);
    chk("stall_ready", req_ready[1], 0);
    @(posedge clk);
    #1 rsp_ready[1] = 1'b1;
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid[1]) cnt++;
      @(posedge clk);
      #1;
    end
    chk("stall_responses", cnt, 3);
    // Reset with responses outstanding; memory must survive
    rsp_ready[1] = 1'b0;
    send(1, 12'h005, 32'hCAFE0005, 4'hF);
    send(1, 12'h006, 32'h12345678, 4'hF);
    rst = 1'b1;
    #1;
    chk("midrst_valid", rsp_valid[1], 0);
    chk("midrst_ready", req_ready[1], 0);
    chk("midrst_rdata", rsp_rdata[1], 0);
    @(posedge clk);
    #1 rst = 1'b0;
    rsp_ready[1] = 1'b1;
    idle(1);
    xfer(1, 12'h005, 32'h0, 4'h0, 32'hCAFE0005, 4'h0, "post_rst_read");
    xfer(1, 12'h006, 32'h0, 4'h0, 32'h12345678, 4'h0, "post_rst_read2");
    // Parity: corrupt bit 9 of a stored word when parity storage exists
    send(0, 12'h007, 32'h0000FF00, 4'hF);
    idle(4);
`ifdef SPRAM_PARITY_EN
    u0.mem[7][9] = ~u0.mem[7][9];
    mm[0][7][9] = ~mm[0][7][9];
    pm[0][7][1] = 1'b1;
    xfer(0, 12'h007, 32'h0, 4'h0, 32'h0000FD00, 4'h2, "parity_flip");
`else
    xfer(0, 12'h007, 32'h0, 4'h0, 32'h0000FF00, 4'h0, "parity_off");
`endif
    fork
      rnd(0);
      rnd(1);
    join
    idle(10);
    for (int k = 0; k < 2; k++) begin
      chk("drain_count", wp[k], rp[k]);
      chk("drain_valid", rsp_valid[k], 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/spram_be_pipe.md
SPRAM_BE_PIPE -- requirements
Module: spram_be_pipe

Interface
REQ-001 Parameter AW, default 12: address width; depth is 2**AW words.
REQ-002 Parameter DW, default 32: data width, SHALL be a multiple of 8; NB = DW/8 byte lanes.
REQ-003 Parameter RD_MODE, default 0: 0 = read-first (old data), 1 = write-first (merged new data).
REQ-004 Parameter OUT_REG, default 0: 1 adds one output pipeline register.
REQ-005 clk  input  1  sole clock; all state on rising edge.
REQ-006 rst  input  1  reset; asynchronous assert, active-high.
REQ-007 req_valid  input  1  request present.
REQ-008 req_ready  output  1  block can accept a request.
REQ-009 req_addr  input  AW  word address.
REQ-010 req_wdata  input  DW  write data.
REQ-011 req_be  input  NB  byte write enables; all-zero = pure read.
REQ-012 rsp_valid  output  1  response present.
REQ-013 rsp_ready  input  1  consumer accepts response.
REQ-014 rsp_rdata  output  DW  read data.
REQ-015 rsp_perr  output  NB  per-byte parity error flags.

Function
REQ-016 A request SHALL be accepted on a cycle where req_valid and req_ready are both 1.
REQ-017 Each accepted request SHALL produce exactly one response, in acceptance order.
REQ-018 On acceptance, byte lane i SHALL be written when req_be[i]=1; the other lanes stay unchanged.
REQ-019 With RD_MODE=0, rsp_rdata SHALL be the word as it was before the write.
REQ-020 With RD_MODE=1, rsp_rdata SHALL be the post-write word: written lanes carry new data, the rest carry old data.
REQ-021 Latency LAT = 1+OUT_REG: with rsp_ready=1, rsp_valid SHALL rise LAT cycles after acceptance.
REQ-022 Throughput SHALL be one request per cycle whenever rsp_ready stays 1.
REQ-023 Internal counter inflight (0..LAT+1) SHALL count accepted requests whose response has not yet been handshaken.
REQ-024 req_ready SHALL equal (inflight < LAT+1), decoded from registered state only; there is no combinational path from rsp_ready or req_valid.
REQ-025 A response buffer of LAT+1 entries SHALL absorb pipeline data while rsp_ready=0; no response is lost or duplicated.
REQ-026 Simultaneous accept and response handshake SHALL leave inflight unchanged.
REQ-027 rsp_rdata and rsp_perr SHALL hold stable while rsp_valid=1 and rsp_ready=0.
REQ-028 Back-to-back accesses to the same address SHALL observe the earlier write; there is no stale-read hazard.
REQ-029 Addresses SHALL be used modulo 2**AW; there is no out-of-range behaviour.

Reset
REQ-030 While rst=1: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_perr=0, inflight=0, pipeline valids=0.
REQ-031 Reset mid-operation SHALL discard all in-flight and buffered responses; memory contents are not reset.
REQ-032 req_ready SHALL rise on the first clk edge after rst deasserts.

Configuration
REQ-033 Macro SPRAM_PARITY_EN defined: each byte lane stores an even-parity bit, written with the data; rsp_perr[i]=1 when the read byte fails parity.
REQ-034 Macro SPRAM_PARITY_EN undefined: no parity storage exists and rsp_perr SHALL be constant 0.

Structure
REQ-035 Package spram_pkg SHALL hold the RD_FIRST/WR_FIRST constants and the byte-parity function.
REQ-036 The response buffer SHALL be sub-module spram_rsp_fifo (parametrised width and depth, valid/ready on both sides).

Verification
REQ-037 DW=32, OUT_REG=0: write 0xDEADBEEF at addr 0x010 with be=0xF, then read 0x010 -> rsp_rdata=0xDEADBEEF one cycle after the read is accepted.
REQ-038 RD_MODE=0 vs 1, word 0x11223344, write 0xAABBCCDD with be=0x5 -> responses 0x11223344 and 0x11BB33DD respectively; a later read returns 0x11BB33DD.
REQ-039 OUT_REG=1, rsp_ready=0 for 10 cycles with continuous req_valid -> exactly 3 accepted, req_ready=0 thereafter; releasing rsp_ready returns 3 responses in order.
REQ-040 Random valid/ready, 10k requests against a reference model -> in-order match, zero loss, zero duplication.
REQ-041 Assert rst with 2 responses outstanding -> rsp_valid=0 immediately; after release, a read returns the pre-reset memory value.
REQ-042 SPRAM_PARITY_EN: force-flip bit 9 of a stored word, then read -> rsp_perr=0x2; without the macro -> rsp_perr=0.
